// File: rtl/icache_dm.sv
// rtl/icache_dm.sv - direct-mapped read-only instruction cache, 64-bit lines
module icache_dm #(
    parameter int INDEX_BITS = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        cpu_stb,
    input  logic [26:0] cpu_addr,
    output logic [31:0] cpu_dout,
    output logic        cpu_ack,
    output logic        cpu_timeout,
    output logic        inst_stb,
    output logic [25:0] inst_addr,
    input  logic [63:0] inst_din,
    input  logic        inst_ack,
    input  logic        inst_timeout
);
    localparam int TAG_BITS = 26 - INDEX_BITS;
    localparam int LINES    = 1 << INDEX_BITS;

    typedef enum logic [2:0] {IDLE, LOOKUP, FILL, RESP, DONE} state_t;
    state_t state_q, state_d;

    logic [63:0]           data_mem [LINES];
    logic [TAG_BITS-1:0]   tag_mem  [LINES];
    logic [63:0]           rd_data_q;
    logic [TAG_BITS-1:0]   rd_tag_q;
    logic [LINES-1:0]      valid_q;

    logic [25:0]           line;
    logic [INDEX_BITS-1:0] index;
    logic [TAG_BITS-1:0]   tag;
    logic                  hit, rd_en, fill_we;
    logic [31:0]           hit_word, fill_word;

    logic [31:0] cpu_dout_q, cpu_dout_d;
    logic        cpu_ack_q, cpu_ack_d;
    logic        cpu_timeout_q, cpu_timeout_d;
    logic        inst_stb_q, inst_stb_d;
    logic [25:0] inst_addr_q, inst_addr_d;

    assign line  = cpu_addr[26:1];
    assign index = line[INDEX_BITS-1:0];
    assign tag   = line[25:INDEX_BITS];

    // Big-endian halves: even word address is the upper half of the line.
    assign hit_word  = cpu_addr[0] ? rd_data_q[31:0] : rd_data_q[63:32];
    assign fill_word = cpu_addr[0] ? inst_din[31:0]  : inst_din[63:32];
    assign hit       = valid_q[index] && (rd_tag_q == tag);

    always_comb begin
        state_d       = state_q;
        cpu_dout_d    = cpu_dout_q;
        cpu_ack_d     = 1'b0;
        cpu_timeout_d = 1'b0;
        inst_stb_d    = inst_stb_q;
        inst_addr_d   = inst_addr_q;
        rd_en         = 1'b0;
        fill_we       = 1'b0;
        case (state_q)
            IDLE: begin
                if (cpu_stb) begin
                    rd_en   = 1'b1;
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                if (hit) begin
                    cpu_dout_d = hit_word;
                    cpu_ack_d  = 1'b1;
                    state_d    = DONE;
                end else begin
                    inst_addr_d = line;
                    inst_stb_d  = 1'b1;
                    state_d     = FILL;
                end
            end
            FILL: begin
                if (inst_ack) begin
                    fill_we    = 1'b1;
                    cpu_dout_d = fill_word;
                    inst_stb_d = 1'b0;
                    state_d    = RESP;
                end else if (inst_timeout) begin
                    inst_stb_d    = 1'b0;
                    cpu_timeout_d = 1'b1;
                    state_d       = DONE;
                end
            end
            RESP: begin
                cpu_ack_d = 1'b1;
                state_d   = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cpu_dout_q    <= '0;
            cpu_ack_q     <= 1'b0;
            cpu_timeout_q <= 1'b0;
            inst_stb_q    <= 1'b0;
            inst_addr_q   <= '0;
        end else begin
            state_q       <= state_d;
            cpu_dout_q    <= cpu_dout_d;
            cpu_ack_q     <= cpu_ack_d;
            cpu_timeout_q <= cpu_timeout_d;
            inst_stb_q    <= inst_stb_d;
            inst_addr_q   <= inst_addr_d;
        end
    end

    // A completing fill sets its line after a coincident flush clears the rest.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else begin
            if (flush) valid_q <= '0;
            if (fill_we) valid_q[index] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (fill_we && rst_n) begin
            data_mem[index] <= inst_din;
            tag_mem[index]  <= tag;
        end
        if (rd_en) begin
            rd_data_q <= data_mem[index];
            rd_tag_q  <= tag_mem[index];
        end
    end

    assign cpu_dout    = cpu_dout_q;
    assign cpu_ack     = cpu_ack_q;
    assign cpu_timeout = cpu_timeout_q;
    assign inst_stb    = inst_stb_q;
    assign inst_addr   = inst_addr_q;
endmodule

// File: tb/tb_icache_dm.sv
// tb/tb_icache_dm.sv - scoreboard bench for icache_dm
module tb_icache_dm;
    logic        clk = 1'b0;
    logic        rst_n, flush, cpu_stb;
    logic [26:0] cpu_addr;
    logic [31:0] cpu_dout;
    logic        cpu_ack, cpu_timeout, inst_stb;
    logic [25:0] inst_addr;
    logic [63:0] inst_din;
    logic        inst_ack, inst_timeout;

    icache_dm #(.INDEX_BITS(8)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .cpu_stb(cpu_stb), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout),
        .cpu_ack(cpu_ack), .cpu_timeout(cpu_timeout),
        .inst_stb(inst_stb), .inst_addr(inst_addr), .inst_din(inst_din),
        .inst_ack(inst_ack), .inst_timeout(inst_timeout)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        to;
        logic [31:0] d;
    } resp_t;

    resp_t       exp_q[$];
    resp_t       mon_e;
    int          checks = 0;
    int          errors = 0;
    int          stb_count = 0;
    int          n;
    logic [25:0] req_addr = '0;
    bit          mem_auto = 1'b1;
    bit          mem_to = 1'b0;
    bit          pulse_ack = 1'b0;
    int          mem_delay = 2;
    logic        prev_ack = 1'b0;
    logic        prev_to = 1'b0;

    function automatic logic [63:0] mem_line(input logic [25:0] a);
        if (a == 26'h8) return 64'h11223344_55667788;
        return {6'd0, a, 6'd1, a};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Memory controller model
    initial begin
        inst_ack = 1'b0;
        inst_timeout = 1'b0;
        inst_din = '0;
        forever begin
            @(posedge clk);
            #1;
            inst_ack = 1'b0;
            inst_timeout = 1'b0;
            if (pulse_ack) begin
                pulse_ack = 1'b0;
                inst_din = mem_line(req_addr);
                inst_ack = 1'b1;
            end else if (inst_stb && mem_auto) begin
                stb_count++;
                req_addr = inst_addr;
                repeat (mem_delay) @(posedge clk);
                #1;
                if (mem_to) inst_timeout = 1'b1;
                else begin
                    inst_din = mem_line(req_addr);
                    inst_ack = 1'b1;
                end
            end
        end
    end

    // Response monitor
    always @(negedge clk) begin
        if (rst_n && (cpu_ack || cpu_timeout)) begin
            chk("ack_timeout_exclusive", {63'd0, cpu_ack & cpu_timeout}, 64'd0);
            chk("single_cycle_pulse", {63'd0, (cpu_ack & prev_ack) | (cpu_timeout & prev_to)}, 64'd0);
            if (exp_q.size() == 0) begin
                chk("unexpected_response", {62'd0, cpu_ack, cpu_timeout}, 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("resp_kind", {63'd0, cpu_timeout}, {63'd0, mon_e.to});
                if (!mon_e.to) chk("cpu_dout", {32'd0, cpu_dout}, {32'd0, mon_e.d});
            end
        end
        prev_ack = cpu_ack;
        prev_to  = cpu_timeout;
    end

    task automatic fetch(input logic [26:0] a, input bit miss, input bit to,
                         input logic [31:0] d, input logic [25:0] ln);
        int c0, cyc;
        bit got;
        c0 = stb_count;
        exp_q.push_back({to, d});
        cpu_addr = a;
        cpu_stb = 1'b1;
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
            got = cpu_ack | cpu_timeout;
        end
        cpu_stb = 1'b0;
        chk("fetch_done", {63'd0, got}, 64'd1);
        if (!miss) chk("hit_latency", 64'(cyc), 64'd2);
        chk("inst_stb_count", 64'(stb_count - c0), {63'd0, miss});
        if (miss) chk("inst_addr", {38'd0, req_addr}, {38'd0, ln});
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        cpu_stb = 1'b0;
        cpu_addr = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cpu_ack", {63'd0, cpu_ack}, 64'd0);
        chk("rst_cpu_timeout", {63'd0, cpu_timeout}, 64'd0);
        chk("rst_inst_stb", {63'd0, inst_stb}, 64'd0);
        chk("rst_cpu_dout", {32'd0, cpu_dout}, 64'd0);
        chk("rst_inst_addr", {38'd0, inst_addr}, 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        fetch(27'h0000010, 1'b1, 1'b0, 32'h11223344, 26'h0000008);
        fetch(27'h0000011, 1'b0, 1'b0, 32'h55667788, 26'h0000008);
        fetch(27'h0000210, 1'b1, 1'b0, 32'h00000108, 26'h0000108);
        fetch(27'h0000010, 1'b1, 1'b0, 32'h11223344, 26'h0000008);

        mem_to = 1'b1;
        mem_delay = 20;
        fetch(27'h0000040, 1'b1, 1'b1, 32'h0, 26'h0000020);
        mem_to = 1'b0;
        mem_delay = 2;
        fetch(27'h0000040, 1'b1, 1'b0, 32'h00000020, 26'h0000020);

        fetch(27'h0000041, 1'b0, 1'b0, 32'h04000020, 26'h0000020);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        fetch(27'h0000010, 1'b1, 1'b0, 32'h11223344, 26'h0000008);
        fetch(27'h0000041, 1'b1, 1'b0, 32'h04000020, 26'h0000020);

        mem_auto = 1'b0;
        cpu_addr = 27'h0000060;
        cpu_stb = 1'b1;
        n = 0;
        while (!inst_stb && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("fill_stb_seen", {63'd0, inst_stb}, 64'd1);
        chk("fill_inst_addr", {38'd0, inst_addr}, {38'd0, 26'h0000030});
        rst_n = 1'b0;
        cpu_stb = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("midfill_rst_inst_stb", {63'd0, inst_stb}, 64'd0);
        req_addr = 26'h0000030;
        @(negedge clk);
        pulse_ack = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("late_ack_inst_stb", {63'd0, inst_stb}, 64'd0);
        mem_auto = 1'b1;
        fetch(27'h0000061, 1'b1, 1'b0, 32'h04000030, 26'h0000030);
        fetch(27'h0000060, 1'b0, 1'b0, 32'h00000030, 26'h0000030);

        repeat (3) @(posedge clk);
        #1;
        chk("exp_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/icache_dm.md
Name: icache_dm

Overview:
- Direct-mapped, read-only instruction cache between the CPU fetch port and the memory controller's 64-bit instruction port.
- Hits are served from on-chip arrays.
- Misses issue one 64-bit line read on inst_stb/inst_addr and wait for inst_ack or inst_timeout.
- A controller timeout is returned to the CPU and nothing is allocated.

Parameters:
- INDEX_BITS, 8, line index width; 2^INDEX_BITS lines of 64 bits each (default 2 KB).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; one clock, synchronous, active-low.
- flush  in  1  one-cycle pulse; invalidates all lines.
- cpu_stb  in  1  fetch request; held high until cpu_ack or cpu_timeout.
- cpu_addr  in  27  word address (byte address bits 28:2), stable while cpu_stb.
- cpu_dout  out  32  instruction word.
- cpu_ack  out  1  one-cycle pulse; cpu_dout valid.
- cpu_timeout  out  1  one-cycle pulse; fetch failed.
- inst_stb  out  1  line read request to the memory controller.
- inst_addr  out  26  64-bit line address, equal to cpu_addr[26:1].
- inst_din  in  64  line data from the memory controller.
- inst_ack  in  1  line data valid.
- inst_timeout  in  1  memory controller gave up.

Behaviour:
- Address split
  - line = cpu_addr[26:1]; index = line[INDEX_BITS-1:0]; tag = line[25:INDEX_BITS].
  - cpu_addr[0] selects the half: 0 gives inst_din/line[63:32], 1 gives [31:0] (big-endian).
- Arrays
  - Data and tag arrays use synchronous-read RAM.
  - The valid vector is flops.
- Reset (rst_n=0 at posedge)
  - All valid bits are cleared.
  - State goes to IDLE.
  - cpu_ack, cpu_timeout and inst_stb are 0; cpu_dout and inst_addr are 0.
  - Reset mid-fill drops the fill; a later inst_ack is ignored because the state is IDLE.
- FSM states: IDLE, LOOKUP, FILL, RESP, DONE.
  - IDLE: if cpu_stb, read the arrays at index and go to LOOKUP.
  - LOOKUP: compare the stored tag with the request tag.
    - Hit (valid and tag equal): drive cpu_dout from the selected half, pulse cpu_ack, go to DONE. Hit latency is stb to ack in 2 cycles.
    - Miss: register inst_addr = line, set inst_stb=1, go to FILL.
  - FILL: inst_stb is held at 1 and inst_addr is held stable.
    - On inst_ack: write inst_din to data[index], tag to tag[index], set valid[index]; capture the selected half into the cpu_dout register; inst_stb=0; go to RESP.
    - On inst_timeout (ack has priority if both are asserted): inst_stb=0; no array or valid update; pulse cpu_timeout; go to DONE.
  - RESP: pulse cpu_ack with the captured word; go to DONE.
  - DONE: one dead cycle so the CPU can drop cpu_stb; go to IDLE.
- Sustained hits therefore take 3 cycles per fetch.
- cpu_ack and cpu_timeout are never asserted together and never for more than 1 cycle.
- cpu_dout keeps its last value when no ack is asserted.
- flush
  - Clears all valid bits at the next posedge in any state.
  - If it coincides with the valid-set of a fill completing, the fill's set wins for that one line; the response is still delivered.
  - A flush during LOOKUP forces a miss if valid is sampled after the flush (valid is read combinationally in LOOKUP).
- inst_ack or inst_timeout arriving outside FILL is ignored.
- Index wrap: lines at addresses differing by 2^INDEX_BITS alias, and the last fill replaces the line.

Test Plan:
- Reset, then fetch cpu_addr=0x0000010, memory line 0x0000008 = 0x11223344_55667788 -> inst_stb once with inst_addr=0x0000008, cpu_ack with cpu_dout=0x11223344.
- Fetch cpu_addr=0x0000011 immediately after -> hit with no inst_stb; cpu_ack 2 cycles after cpu_stb; cpu_dout=0x55667788.
- Fetch cpu_addr=0x0000010 + (2^9) with INDEX_BITS=8 (same index, different tag) -> miss refill. A subsequent fetch of 0x0000010 misses again (alias eviction).
- Miss where the memory model asserts inst_timeout after 20 cycles -> one cpu_timeout pulse, no cpu_ack. A retry of the same address misses again, proving no allocation.
- Fill two lines, pulse flush, refetch both -> both miss and issue inst_stb.
- Drop rst_n for one cycle while in FILL, then have the memory model assert inst_ack -> no cpu_ack, valid[index]=0, next fetch of that address misses.
